mac_result_collector: RTL and testbench
=======================================

Name: mac_result_collector

Overview:
- Downstream consumer of the MAC datapath and its NOP-tracking pipeline.
- Takes the adder output together with the delayed NOP flag, drops NOP slots, and accumulates VEC_LEN valid sums into one dot-product result.
- Queues completed results in a small FIFO that drains through a valid/ready port.
- Raises stall_req to the issue logic because the 7-cycle MAC pipeline cannot be stalled mid-flight.

Parameters:
- DATA_W, 32, width of the signed adder output feeding this block
- ACC_W, 40, signed accumulator and result width; must satisfy ACC_W >= DATA_W
- VEC_LEN, 8, valid elements per result; must satisfy VEC_LEN >= 2
- FIFO_DEPTH, 8, result queue entries; must be a power of 2 and >= 4
- STALL_MARGIN, 2, free-entry threshold at which stall_req asserts

Ports:
- clk  in  1  rising-edge clock
- aclr_n  in  1  asynchronous active-low reset
- sclr  in  1  synchronous flush, pulsed together with the NOP pipeline's sclr
- nop_in  in  1  1 = slot carries no data (driven by the NOP pipeline output)
- data_in  in  DATA_W  signed MAC sum, aligned with nop_in
- res_data  out  ACC_W  signed result at the FIFO head
- res_valid  out  1  FIFO head valid
- res_ready  in  1  consumer accepts the head
- stall_req  out  1  registered request to stop issuing new operands
- elem_cnt  out  $clog2(VEC_LEN)  elements accumulated in the current vector
- ovf_err  out  1  sticky: signed accumulator overflow occurred
- drop_err  out  1  sticky: a completed result was lost because the FIFO was full

Behaviour:
- Reset: aclr_n low asynchronously clears acc, elem_cnt, FIFO pointers and occupancy, ovf_err and drop_err.
  - All outputs read 0 while reset is asserted: res_data=0, res_valid=0, stall_req=0.
  - sclr high at a clock edge gives the same cleared state synchronously. sclr overrides every other event in that cycle.
- Valid slot: nop_in=0 at a clock edge.
  - data_in is sign-extended to ACC_W and added to acc. The addition wraps modulo 2^ACC_W.
  - ovf_err sets when both operands share a sign and the sum's sign differs.
- Non-final valid slot (elem_cnt < VEC_LEN-1): acc <= acc+ext(data_in); elem_cnt increments.
- Final valid slot (elem_cnt == VEC_LEN-1): push acc+ext(data_in) into the FIFO, then acc <= 0 and elem_cnt <= 0 in the same edge.
- NOP slot: acc and elem_cnt hold; data_in is ignored, including X.
- FIFO:
  - Registered write, first-word-fall-through read.
  - A push at edge t makes the entry visible at the head with res_valid=1 after edge t, provided the FIFO was empty.
  - Pop occurs when res_valid and res_ready are both 1.
  - res_data holds stable while res_valid=1 and res_ready=0.
  - res_ready while res_valid=0 has no effect. res_data may change when empty.
- Push and pop in the same edge:
  - Occupancy is unchanged. This is legal even when the FIFO is full, because the pop frees the slot.
  - When empty, only a push occurs; the head becomes valid the following cycle.
- Push while full with no pop: the result is discarded, drop_err sets, and acc/elem_cnt still restart.
- Pointer wrap-around at FIFO_DEPTH is modulo. Occupancy counts 0..FIFO_DEPTH.
- stall_req <= (occupancy_next >= FIFO_DEPTH-STALL_MARGIN), registered, giving 1-cycle latency.
- Throughput: one input per cycle; at most one push per VEC_LEN valid cycles.

Decomposition:
- Shared package mac_pkg: MAC_LATENCY=7 (multiply 5 + add 2), DATA_W, ACC_W, and the FIFO_DEPTH default.
  - The NOP pipeline's stage count and this block's STALL_MARGIN derivation both come from MAC_LATENCY.
- One sub-module: mac_result_fifo, a parameterised FWFT FIFO with aclr_n/sclr, full/empty and occupancy outputs.
  - Accumulator, counter and error logic stay in mac_result_collector.

Test Plan:
- VEC_LEN=8, data_in=1..8 on consecutive valid cycles, res_ready=1 -> exactly one result of 36, with res_valid high for one cycle, one edge after the 8th input.
- Same stream with nop_in=1 on alternate cycles and data_in=X during NOPs -> result still 36; elem_cnt holds across NOP cycles.
- data_in=-5 repeated for 16 valid cycles -> two results of -40 each, sign-extended to ACC_W; ovf_err=0.
- res_ready=0 while 6 results are produced -> stall_req=1 once occupancy reaches 6. Further results fill the FIFO; the 9th completed result sets drop_err. Then res_ready=1 -> 8 results drain in order, stall_req drops.
- Drive 0x7FFFFFFF for 512 valid cycles with ACC_W=40 -> ovf_err sets on the wrapping add and stays set until reset.
- aclr_n pulse at elem_cnt=5 with 2 queued results -> res_valid=0, elem_cnt=0 and flags=0 immediately. The next 8 inputs of value 1 yield a result of 8. Repeat using sclr: same outcome, with the clear taking effect at the edge.

Source files
------------

// File: rtl/mac_pkg.sv
// Constants shared by the MAC datapath, its NOP-tracking pipeline and the result collector.
package mac_pkg;

   localparam int MAC_LATENCY    = 7;   // multiply 5 + add 2
   localparam int MAC_DATA_W     = 32;
   localparam int MAC_ACC_W      = 40;
   localparam int MAC_VEC_LEN    = 8;
   localparam int MAC_FIFO_DEPTH = 8;

   // Completions that can still land after stall_req is seen: ceil(latency / vector length)
   // results in flight, plus one for the registered stall itself.
   localparam int MAC_STALL_MARGIN = (MAC_LATENCY + MAC_VEC_LEN - 1) / MAC_VEC_LEN + 1;

   typedef enum logic [1:0] {
      SLOT_NOP,
      SLOT_ACC,
      SLOT_LAST
   } slot_e;

   // Two's-complement overflow: operands agree in sign but the sum does not.
   function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
      return (a_msb == b_msb) && (s_msb != a_msb);
   endfunction

endpackage

// File: rtl/mac_result_fifo.sv
// First-word-fall-through result queue with registered write, async/sync clear and occupancy.
module mac_result_fifo #(
   parameter int WIDTH = 40,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     aclr_n,
   input  logic                     sclr,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_wr;
   logic             w_rd;

   assign empty = (r_count == '0);
   assign full  = (r_count == CW'(DEPTH));
   assign count = r_count;

   // A pop in the same edge frees the slot, so a write into a full queue is still accepted.
   assign w_rd = rd_en && !empty;
   assign w_wr = wr_en && (!full || w_rd);

   assign rd_data = empty ? '0 : r_mem[r_rd_ptr];

   always_ff @(posedge clk or negedge aclr_n) begin
      if (!aclr_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (sclr) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= r_count + CW'(w_wr) - CW'(w_rd);
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr && !sclr) r_mem[r_wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/mac_result_collector.sv
// Drops NOP slots from the MAC output, accumulates VEC_LEN sums per result and queues the
// results behind a valid/ready port, requesting an issue stall before the queue can overflow.
module mac_result_collector
   import mac_pkg::*;
#(
   parameter int DATA_W       = MAC_DATA_W,
   parameter int ACC_W        = MAC_ACC_W,
   parameter int VEC_LEN      = MAC_VEC_LEN,
   parameter int FIFO_DEPTH   = MAC_FIFO_DEPTH,
   parameter int STALL_MARGIN = MAC_STALL_MARGIN
) (
   input  logic                        clk,
   input  logic                        aclr_n,
   input  logic                        sclr,
   input  logic                        nop_in,
   input  logic signed [DATA_W-1:0]    data_in,
   output logic signed [ACC_W-1:0]     res_data,
   output logic                        res_valid,
   input  logic                        res_ready,
   output logic                        stall_req,
   output logic [$clog2(VEC_LEN)-1:0]  elem_cnt,
   output logic                        ovf_err,
   output logic                        drop_err
);

   localparam int CNT_W = $clog2(VEC_LEN);
   localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;

   logic signed [ACC_W-1:0] r_acc;
   logic [CNT_W-1:0]        r_elem_cnt;
   logic                    r_ovf;
   logic                    r_drop;
   logic                    r_stall;

   logic signed [ACC_W-1:0] w_ext;
   logic signed [ACC_W-1:0] w_sum;
   slot_e                   w_slot;
   logic                    w_push;
   logic                    w_full;
   logic                    w_empty;
   logic [OCC_W-1:0]        w_count;
   logic [ACC_W-1:0]        w_fifo_rd;
   logic                    w_pop_acc;
   logic                    w_push_acc;
   logic                    w_drop;
   logic [OCC_W-1:0]        w_occ_next;

   assign w_ext = ACC_W'(data_in);
   assign w_sum = r_acc + w_ext;

   always_comb begin
      w_slot = SLOT_NOP;
      if (!nop_in) begin
         w_slot = (r_elem_cnt == CNT_W'(VEC_LEN - 1)) ? SLOT_LAST : SLOT_ACC;
      end
   end

   assign w_push     = (w_slot == SLOT_LAST) && !sclr;
   assign w_pop_acc  = res_ready && !w_empty;
   assign w_push_acc = w_push && (!w_full || w_pop_acc);
   assign w_drop     = w_push && w_full && !w_pop_acc;
   assign w_occ_next = w_count + OCC_W'(w_push_acc) - OCC_W'(w_pop_acc);

   mac_result_fifo #(
      .WIDTH (ACC_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .aclr_n  (aclr_n),
      .sclr    (sclr),
      .wr_en   (w_push),
      .wr_data (w_sum),
      .rd_en   (res_ready),
      .rd_data (w_fifo_rd),
      .full    (w_full),
      .empty   (w_empty),
      .count   (w_count)
   );

   always_ff @(posedge clk or negedge aclr_n) begin
      if (!aclr_n) begin
         r_acc      <= '0;
         r_elem_cnt <= '0;
         r_ovf      <= 1'b0;
         r_drop     <= 1'b0;
         r_stall    <= 1'b0;
      end else if (sclr) begin
         r_acc      <= '0;
         r_elem_cnt <= '0;
         r_ovf      <= 1'b0;
         r_drop     <= 1'b0;
         r_stall    <= 1'b0;
      end else begin
         case (w_slot)
            SLOT_ACC: begin
               r_acc      <= w_sum;
               r_elem_cnt <= r_elem_cnt + CNT_W'(1);
            end
            SLOT_LAST: begin
               r_acc      <= '0;
               r_elem_cnt <= '0;
            end
            default: ;
         endcase
         if ((w_slot != SLOT_NOP) && add_ovf(r_acc[ACC_W-1], w_ext[ACC_W-1], w_sum[ACC_W-1])) begin
            r_ovf <= 1'b1;
         end
         if (w_drop) r_drop <= 1'b1;
         r_stall <= (w_occ_next >= OCC_W'(FIFO_DEPTH - STALL_MARGIN));
      end
   end

   assign res_data  = w_fifo_rd;
   assign res_valid = !w_empty;
   assign stall_req = r_stall;
   assign elem_cnt  = r_elem_cnt;
   assign ovf_err   = r_ovf;
   assign drop_err  = r_drop;

endmodule

// File: tb/tb_mac_result_collector.sv
// Scoreboard bench for mac_result_collector: a queue-based reference model predicts results,
// occupancy and flags; a negedge monitor checks every result handed over on the output port.
module tb_mac_result_collector;

   localparam int DW  = 32;
   localparam int AW  = 40;
   localparam int VL  = 8;
   localparam int FD  = 8;
   localparam int SM  = 2;
   localparam int VL2 = 512;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 aclr_n, sclr, nop_in, res_ready;
   logic signed [DW-1:0] data_in;
   logic signed [AW-1:0] res_data;
   logic                 res_valid, stall_req, ovf_err, drop_err;
   logic [2:0]           elem_cnt;

   logic                 sclr2, nop2, ready2;
   logic signed [DW-1:0] data2;
   logic signed [AW-1:0] res_data2;
   logic                 res_valid2, stall2, ovf2, drop2;
   logic [8:0]           elem_cnt2;

   mac_result_collector #(
      .DATA_W(DW), .ACC_W(AW), .VEC_LEN(VL), .FIFO_DEPTH(FD), .STALL_MARGIN(SM)
   ) dut (
      .clk(clk), .aclr_n(aclr_n), .sclr(sclr), .nop_in(nop_in), .data_in(data_in),
      .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
      .stall_req(stall_req), .elem_cnt(elem_cnt), .ovf_err(ovf_err), .drop_err(drop_err)
   );

   mac_result_collector #(
      .DATA_W(DW), .ACC_W(AW), .VEC_LEN(VL2), .FIFO_DEPTH(FD), .STALL_MARGIN(SM)
   ) dut_ovf (
      .clk(clk), .aclr_n(aclr_n), .sclr(sclr2), .nop_in(nop2), .data_in(data2),
      .res_data(res_data2), .res_valid(res_valid2), .res_ready(ready2),
      .stall_req(stall2), .elem_cnt(elem_cnt2), .ovf_err(ovf2), .drop_err(drop2)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic signed [AW-1:0] exp_q[$];
   longint m_acc;
   int     m_cnt, m_occ;
   bit     m_ovf, m_drop, m_stall;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic longint wrap_acc(input longint v);
      return (v <<< (64 - AW)) >>> (64 - AW);
   endfunction

   task automatic model_clear();
      m_acc = 0; m_cnt = 0; m_occ = 0;
      m_ovf = 0; m_drop = 0; m_stall = 0;
      exp_q.delete();
   endtask

   // One clock of stimulus: predict the edge, let it happen, then compare the visible state.
   task automatic step(input bit nop, input longint d, input bit rdy, input bit clr);
      bit     pop;
      longint s;
      nop_in    = nop;
      sclr      = clr;
      res_ready = clr ? 1'b0 : rdy;
      if (nop) data_in = 'x;
      else     data_in = DW'(d);
      if (clr) begin
         model_clear();
      end else begin
         pop = rdy && (m_occ > 0);
         if (!nop) begin
            s = m_acc + d;
            if (s != wrap_acc(s)) m_ovf = 1;
            s = wrap_acc(s);
            if (m_cnt == VL - 1) begin
               m_acc = 0;
               m_cnt = 0;
               if (m_occ == FD && !pop) m_drop = 1;
               else begin
                  exp_q.push_back(AW'(s));
                  m_occ++;
               end
            end else begin
               m_acc = s;
               m_cnt++;
            end
         end
         if (pop) m_occ--;
         m_stall = (m_occ >= FD - SM);
      end
      @(posedge clk);
      #1;
      chk("res_valid", res_valid, m_occ > 0);
      chk("elem_cnt", elem_cnt, m_cnt);
      chk("stall_req", stall_req, m_stall);
      chk("ovf_err", ovf_err, m_ovf);
      chk("drop_err", drop_err, m_drop);
   endtask

   task automatic do_aclr();
      res_ready = 0; nop_in = 1; sclr = 0;
      ready2 = 0; nop2 = 1;
      #2 aclr_n = 0;
      #1;
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_data", res_data, 0);
      chk("rst_elem_cnt", elem_cnt, 0);
      chk("rst_stall", stall_req, 0);
      chk("rst_ovf", ovf_err, 0);
      chk("rst_drop", drop_err, 0);
      chk("rst_ovf2", ovf2, 0);
      model_clear();
      #3 aclr_n = 1;
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (aclr_n && res_valid && res_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_result: got %0d expected none", res_data);
         end else begin
            chk("res_data", res_data, exp_q.pop_front());
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      longint acc2, s2;
      int     cnt2;
      bit     ovf2_m;

      aclr_n = 0; sclr = 0; nop_in = 1; data_in = '0; res_ready = 0;
      sclr2 = 0; nop2 = 1; data2 = '0; ready2 = 0;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      chk("init_res_valid", res_valid, 0);
      chk("init_res_data", res_data, 0);
      chk("init_stall", stall_req, 0);
      chk("init_elem_cnt", elem_cnt, 0);
      chk("init_flags", {ovf_err, drop_err}, 0);
      aclr_n = 1;
      @(posedge clk);
      #1;

      // 1..8 back to back
      for (int i = 1; i <= VL; i++) step(0, i, 1, 0);
      chk("t1_valid", res_valid, 1);
      chk("t1_sum", res_data, 36);
      step(1, 0, 1, 0);
      chk("t1_one_cycle", res_valid, 0);
      repeat (2) step(1, 0, 1, 0);

      // Same stream interleaved with NOPs carrying X
      for (int i = 1; i <= VL; i++) begin
         step(1, 0, 1, 0);
         step(0, i, 1, 0);
      end
      chk("t2_sum", res_data, 36);
      repeat (2) step(1, 0, 1, 0);

      // Negative operands
      for (int i = 0; i < 2 * VL; i++) begin
         step(0, -5, 1, 0);
         if (i == VL - 1) chk("t3_first", res_data, -40);
      end
      chk("t3_second", res_data, -40);
      chk("t3_ovf", ovf_err, 0);
      repeat (2) step(1, 0, 1, 0);

      // Back-pressure: fill, stall, drop, then drain
      for (int r = 1; r <= FD + 1; r++) begin
         for (int i = 0; i < VL; i++) step(0, r * 100 + i, 0, 0);
         if (r == 5) chk("t4_no_stall_at5", stall_req, 0);
         if (r == 6) chk("t4_stall_at6", stall_req, 1);
         if (r == FD) chk("t4_no_drop_full", drop_err, 0);
      end
      chk("t4_drop", drop_err, 1);
      repeat (FD + 2) step(1, 0, 1, 0);
      chk("t4_drained", exp_q.size(), 0);
      chk("t4_stall_low", stall_req, 0);

      // Async reset mid-vector with queued results
      for (int i = 0; i < 2 * VL + 5; i++) step(0, 3, 0, 0);
      chk("t5_elem5", elem_cnt, 5);
      do_aclr();
      for (int i = 0; i < VL; i++) step(0, 1, 1, 0);
      chk("t5_after_aclr", res_data, 8);
      repeat (2) step(1, 0, 1, 0);

      // Same with the synchronous flush
      for (int i = 0; i < 2 * VL + 5; i++) step(0, 3, 0, 0);
      chk("t6_elem5", elem_cnt, 5);
      step(0, 7, 0, 1);
      chk("t6_sclr_valid", res_valid, 0);
      chk("t6_sclr_cnt", elem_cnt, 0);
      for (int i = 0; i < VL; i++) step(0, 1, 1, 0);
      chk("t6_after_sclr", res_data, 8);
      repeat (2) step(1, 0, 1, 0);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 9) < 3), longint'(int'($urandom)), ($urandom_range(0, 9) < 7), 0);
      end
      repeat (FD + 4) step(1, 0, 1, 0);
      chk("rand_drained", exp_q.size(), 0);

      // Overflow on the long-vector instance
      acc2 = 0; cnt2 = 0; ovf2_m = 0;
      ready2 = 1;
      for (int i = 0; i < VL2 + 40; i++) begin
         nop2  = 0;
         data2 = 32'h7FFF_FFFF;
         s2 = acc2 + 64'sh7FFF_FFFF;
         if (s2 != wrap_acc(s2)) ovf2_m = 1;
         s2 = wrap_acc(s2);
         if (cnt2 == VL2 - 1) begin
            acc2 = 0;
            cnt2 = 0;
         end else begin
            acc2 = s2;
            cnt2++;
         end
         @(posedge clk);
         #1;
         chk("ovf2_flag", ovf2, ovf2_m);
         chk("ovf2_cnt", elem_cnt2, cnt2);
         if (i == VL2 - 1) begin
            chk("ovf2_res_valid", res_valid2, 1);
            chk("ovf2_res", res_data2, s2);
         end
      end
      nop2 = 1;
      repeat (5) @(posedge clk);
      #1;
      chk("ovf2_sticky", ovf2, 1);
      chk("ovf2_no_drop", {stall2, drop2}, 0);
      do_aclr();
      chk("ovf2_cleared", ovf2, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
